// File: rtl/dungv_pkg.sv
// Shared definitions for the instruction sequencer.
//   - default widths for the program counter, instruction word and retire count
//   - sequencer state encoding and instruction flag encoding
//   - HALT instruction word and small decode helpers
package dungv_pkg;

  localparam int unsigned PC_W_DEFAULT    = 10;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned INSTR_W         = 30;
  localparam int unsigned RETIRED_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_RETIRE = 3'd5,
    S_HALT   = 3'd6
  } seq_state_e;

  // Instruction class lives in the top two bits of the word.
  typedef enum logic [1:0] {
    FLAG_NOP    = 2'd0,
    FLAG_ALU_RR = 2'd1,
    FLAG_ALU_RI = 2'd2,
    FLAG_MEM    = 2'd3
  } instr_flag_e;

  // A flag-0 word whose payload is all ones stops the sequencer.
  localparam logic [INSTR_W-1:0] HALT_WORD = 30'h0FFF_FFFF;

  function automatic instr_flag_e get_flag(input logic [INSTR_W-1:0] instr);
    return instr_flag_e'(instr[INSTR_W-1 -: 2]);
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr == HALT_WORD);
  endfunction

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// seq_watchdog: wait-cycle counter for the EXEC/MEM states.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   clear_i     : return the count to zero (has priority over enable_i)
//   enable_i    : this cycle is a waiting cycle; count it
//   expired_o   : this waiting cycle is the TIMEOUT-th one
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count_d = count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_d;
    end
  end

  // Flagged during the waiting cycle that brings the count up to TIMEOUT,
  // so the FSM leaves on the same edge the count reaches the limit.
  assign expired_o = enable_i && !clear_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch / decode / execute sequencer for 30-bit instructions.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start, start_addr               : launch execution at start_addr (IDLE/HALT only)
//   imem_req, imem_addr             : instruction fetch request and address
//   imem_rdata, imem_rvalid         : fetched word and its valid strobe
//   instr_out, instr_valid          : instruction to decoder, one-cycle strobe
//   exec_start, exec_done           : ALU start pulse and completion
//   mem_start, mem_done             : memory start pulse and completion
//   pc, busy, halted                : current address and status
//   timeout_err                     : sticky, set when a wait state times out
//   retired                         : saturating retired-instruction count
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_FETCH  | imem_req high at pc until imem_rvalid
// S_DECODE | instr_valid high for this one cycle
// S_EXEC   | exec_start in first cycle, then wait for exec_done
// S_MEM    | mem_start in first cycle, then wait for mem_done
// S_RETIRE | advance pc, count the instruction
// S_HALT   | stopped; start reloads pc and refetches
module instr_sequencer
  import dungv_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  input  logic                 imem_rvalid,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 instr_valid,
  output logic                 exec_start,
  input  logic                 exec_done,
  output logic                 mem_start,
  input  logic                 mem_done,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [RETIRED_W-1:0] retired
);

  seq_state_e             state_q;
  logic [PC_W-1:0]        pc_q;
  logic [PC_W-1:0]        pc_d;
  logic [INSTR_W-1:0]     instr_q;
  logic [RETIRED_W-1:0]   retired_q;
  logic [RETIRED_W-1:0]   retired_d;
  logic                   imem_req_q;
  logic                   instr_valid_q;
  logic                   exec_start_q;
  logic                   mem_start_q;
  logic                   busy_q;
  logic                   halted_q;
  logic                   timeout_err_q;

  logic in_wait;
  logic sampling;
  logic done_sel;
  logic wd_expired;

  assign pc_d      = pc_q + PC_W'(1);
  assign retired_d = (retired_q == '1) ? retired_q : retired_q + RETIRED_W'(1);

  assign in_wait  = (state_q == S_EXEC) || (state_q == S_MEM);
  // The start pulse cycle is not a sampling cycle: a done coincident with it
  // belongs to a previous operation and is dropped.
  assign sampling = in_wait && !(exec_start_q || mem_start_q);
  assign done_sel = (state_q == S_EXEC) ? exec_done : mem_done;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!in_wait),
    .enable_i  (sampling && !done_sel),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      retired_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      exec_start_q  <= 1'b0;
      mem_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      exec_start_q  <= 1'b0;
      mem_start_q   <= 1'b0;

      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_q          <= start_addr;
            timeout_err_q <= 1'b0;
            imem_req_q    <= 1'b1;
            busy_q        <= 1'b1;
            halted_q      <= 1'b0;
            state_q       <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (get_flag(instr_q))
            FLAG_NOP: begin
              if (is_halt(instr_q)) begin
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else begin
                state_q  <= S_RETIRE;
              end
            end
            FLAG_ALU_RR, FLAG_ALU_RI: begin
              exec_start_q <= 1'b1;
              state_q      <= S_EXEC;
            end
            FLAG_MEM: begin
              mem_start_q <= 1'b1;
              state_q     <= S_MEM;
            end
          endcase
        end

        S_EXEC, S_MEM: begin
          if (sampling && done_sel) begin
            state_q <= S_RETIRE;
          end else if (wd_expired) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            halted_q      <= 1'b1;
            state_q       <= S_HALT;
          end
        end

        S_RETIRE: begin
          pc_q       <= pc_d;
          retired_q  <= retired_d;
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end

        default: begin
          imem_req_q <= 1'b0;
          busy_q     <= 1'b0;
          halted_q   <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = instr_valid_q;
  assign exec_start  = exec_start_q;
  assign mem_start   = mem_start_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign retired     = retired_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning program-counter and instruction-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning maximum cycles to wait for exec_done/mem_done.
REQ-003 The block SHALL have ports: clk  input  1  sole clock, all state on rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have ports: start  input  1  begin execution; start_addr  input  PC_W  first instruction address.
REQ-005 The block SHALL have ports: imem_req  output  1  fetch request; imem_addr  output  PC_W  fetch address; imem_rdata  input  30  fetched instruction; imem_rvalid  input  1  rdata valid.
REQ-006 The block SHALL have ports: instr_out  output  30  instruction to decoder; instr_valid  output  1  one-cycle decode strobe.
REQ-007 The block SHALL have ports: exec_start  output  1  ALU start pulse; exec_done  input  1  ALU complete; mem_start  output  1  memory start pulse; mem_done  input  1  memory complete.
REQ-008 The block SHALL have ports: pc  output  PC_W  current address; busy  output  1  not IDLE/HALT; halted  output  1  in HALT; timeout_err  output  1  sticky timeout flag; retired  output  16  retired-instruction count.

Function
REQ-009 Instruction flag field SHALL be instr[29:28]: 0 no-op, 1 register ALU, 2 register/immediate ALU, 3 memory.
REQ-010 HALT instruction SHALL be flag 0 with instr[27:0] all ones; any other flag-0 word is a no-op.
REQ-011 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, RETIRE, HALT.
REQ-012 IDLE: on start=1, pc loads start_addr, next state FETCH; start ignored in all other states except HALT.
REQ-013 FETCH: imem_req=1 and imem_addr=pc every cycle until imem_rvalid=1; rdata captured into instr_out that cycle, next state DECODE.
REQ-014 DECODE: instr_valid=1 for exactly one cycle; next state EXEC for flag 1/2, MEM for flag 3, RETIRE for no-op, HALT for HALT word.
REQ-015 Decoder output SHALL be treated as valid one cycle after instr_valid; exec_start/mem_start SHALL pulse one cycle, in the first EXEC/MEM cycle.
REQ-016 exec_done/mem_done SHALL be sampled only from the cycle after the start pulse; done coincident with the start pulse is ignored.
REQ-017 EXEC/MEM: on done=1 next state RETIRE; wait counter increments each waiting cycle; on reaching TIMEOUT, timeout_err=1 and next state HALT.
REQ-018 RETIRE: pc <= pc+1 modulo 2^PC_W (2^PC_W-1 wraps to 0); retired increments, saturating at 16'hFFFF; next state FETCH.
REQ-019 HALT: halted=1, pc frozen; start=1 SHALL go to IDLE-equivalent load (pc<=start_addr, clear timeout_err, next FETCH); retired is not cleared.
REQ-020 imem_rvalid outside FETCH, and done inputs outside their wait state, SHALL be ignored.
REQ-021 HALT word SHALL not increment retired.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state IDLE, pc=0, instr_out=0, retired=0, timeout_err=0, wait counter=0, all strobes/req=0, busy=0, halted=0.
REQ-023 Reset mid-operation SHALL abandon the outstanding fetch/exec/mem with no further strobes; deassertion is synchronized externally.

Structure
REQ-024 State encoding, flag encodings, HALT-word constant and default widths SHALL live in shared package dungv_pkg.
REQ-025 The timeout counter SHALL be sub-module seq_watchdog (clear, enable, expired; TIMEOUT parameter).
REQ-026 Implementation SHALL use one registered state machine with registered outputs; no combinational path from inputs to imem_req.

Verification
REQ-027 start, start_addr=5, rvalid after 2 cycles, word flag 1, exec_done 3 cycles later -> imem_addr=5, one instr_valid, one exec_start, pc=6, retired=1.
REQ-028 flag-3 word, mem_done coincident with mem_start then 1 cycle later -> coincident done ignored, RETIRE after second.
REQ-029 pc=1023 no-op retire -> pc wraps to 0, next fetch address 0.
REQ-030 flag-2 word, exec_done never asserted, TIMEOUT=255 -> timeout_err and halted after 255 wait cycles; start clears error, refetches start_addr.
REQ-031 HALT word 30'h0FFF_FFFF -> halted=1, busy=0, retired unchanged; rst_n pulsed during EXEC -> all outputs reset values immediately.
